// File: rtl/fetch_unit.sv
// fetch_unit: sequential-PC instruction fetch with in-order response tagging, skid buffering and redirect flush.
// Optional feature: define FETCH_STALL_CNT_EN to build the saturating queue-full stall counter.
module fetch_unit #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        q_full,
  output logic        q_write_en,
  output logic [63:0] q_write_data,
  output logic [31:0] stall_cycles
);
  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CW-1:0] MAXC = CW'(MAX_OUTSTANDING);
  localparam logic [PW-1:0] LAST = PW'(MAX_OUTSTANDING - 1);

  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] skid_cnt_q, skid_cnt_d;
  logic [PW-1:0] tag_wp_q, tag_wp_d, tag_rp_q, tag_rp_d;
  logic [PW-1:0] skid_wp_q, skid_wp_d, skid_rp_q, skid_rp_d;
  logic [31:0]   tag_mem  [MAX_OUTSTANDING];
  logic [63:0]   skid_mem [MAX_OUTSTANDING];
  logic [CW-1:0] occ;
  logic          resp_ok, live_resp, issue, skid_nz, skid_push, skid_pop;
  logic [63:0]   resp_entry;
  logic          unused_rpc;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  assign unused_rpc = ^redirect_pc[1:0];

  // Datapath decode: a response is live only if it is expected, not stale and not killed by a redirect.
  always_comb begin
    resp_ok        = imem_resp_valid && out_q != '0;
    live_resp      = resp_ok && drop_q == '0 && !redirect_valid;
    occ            = out_q + skid_cnt_q;
    imem_req_valid = !reset && !redirect_valid && occ < MAXC;
    imem_req_addr  = pc_q;
    issue          = imem_req_valid && imem_req_ready;
    skid_nz        = skid_cnt_q != '0;
    q_write_en     = !q_full && !redirect_valid && (skid_nz || live_resp);
    resp_entry     = {tag_mem[tag_rp_q], imem_resp_data};
    q_write_data   = skid_nz ? skid_mem[skid_rp_q] : resp_entry;
    skid_pop       = q_write_en && skid_nz;
    skid_push      = live_resp && (skid_nz || q_full);
  end

  // Next-state: redirect wins, restarting the PC, clearing the skid and arming the drop counter.
  always_comb begin
    pc_d       = redirect_valid ? {redirect_pc[31:2], 2'b00} : issue ? pc_q + 32'd4 : pc_q;
    out_d      = out_q + CW'(issue) - CW'(resp_ok);
    drop_d     = redirect_valid ? out_q - CW'(resp_ok) : (resp_ok && drop_q != '0) ? drop_q - CW'(1) : drop_q;
    skid_cnt_d = redirect_valid ? '0 : skid_cnt_q + CW'(skid_push) - CW'(skid_pop);
    skid_wp_d  = redirect_valid ? '0 : skid_push ? inc(skid_wp_q) : skid_wp_q;
    skid_rp_d  = redirect_valid ? '0 : skid_pop ? inc(skid_rp_q) : skid_rp_q;
    tag_wp_d   = issue ? inc(tag_wp_q) : tag_wp_q;
    tag_rp_d   = resp_ok ? inc(tag_rp_q) : tag_rp_q;
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      out_q      <= '0;
      drop_q     <= '0;
      skid_cnt_q <= '0;
      skid_wp_q  <= '0;
      skid_rp_q  <= '0;
      tag_wp_q   <= '0;
      tag_rp_q   <= '0;
    end else begin
      pc_q       <= pc_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
      skid_cnt_q <= skid_cnt_d;
      skid_wp_q  <= skid_wp_d;
      skid_rp_q  <= skid_rp_d;
      tag_wp_q   <= tag_wp_d;
      tag_rp_q   <= tag_rp_d;
    end
  end

  // Storage: tags capture the issued PC, skid captures responses the queue cannot take now.
  always_ff @(posedge clk) begin
    if (issue) tag_mem[tag_wp_q] <= pc_q;
    if (skid_push) skid_mem[skid_wp_q] <= resp_entry;
  end

  // A response with nothing outstanding is a memory protocol violation.
  always_ff @(posedge clk) begin
    if (!reset) assert (!(imem_resp_valid && out_q == '0));
  end

`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;
  assign stall_d = (q_full && (skid_nz || live_resp) && stall_q != '1) ? stall_q + 32'd1 : stall_q;
  // Saturating count of cycles where a ready entry is blocked by a full queue.
  always_ff @(posedge clk) begin
    if (reset) stall_q <= '0;
    else stall_q <= stall_d;
  end
  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vector table plus randomized run against a queue-based fetch reference model.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        q_full, q_write_en;
  logic [63:0] q_write_data;
  logic [31:0] stall_cycles;
  int cmp = 0;
  int errs = 0;

  fetch_unit #(.RESET_PC(32'h100), .MAX_OUTSTANDING(2)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .q_full(q_full), .q_write_en(q_write_en), .q_write_data(q_write_data),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, rdy, rsp;
    logic [31:0] rdata;
    logic        redir;
    logic [31:0] rpc;
    logic        full;
    logic        erv;
    logic [31:0] eaddr;
    logic        ewe;
    logic [63:0] ewd;
  } vec_t;

  typedef struct {
    logic [31:0] a;
    int          due;
    int          ep;
  } mreq_t;

  localparam logic [31:0] I0 = 32'hA0A0_0001, I1 = 32'hA0A0_0002, I2 = 32'hA0A0_0003;
  localparam logic [31:0] X0 = 32'hDEAD_0000, X1 = 32'hDEAD_0001, J0 = 32'hB0B0_0000;
  localparam logic [31:0] J1 = 32'hDEAD_0002, K0 = 32'hC0C0_0000, K1 = 32'hC0C0_0001;

  function automatic vec_t v(input logic rst, rdy, rsp, input logic [31:0] rd, input logic redir,
                             input logic [31:0] rpc, input logic full, input logic erv,
                             input logic [31:0] ea, input logic ewe, input logic [63:0] ewd);
    vec_t t;
    t.rst = rst; t.rdy = rdy; t.rsp = rsp; t.rdata = rd; t.redir = redir; t.rpc = rpc;
    t.full = full; t.erv = erv; t.eaddr = ea; t.ewe = ewe; t.ewd = ewd;
    return t;
  endfunction

  function automatic logic [31:0] ins(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check(input string n, input logic [63:0] a, input logic [63:0] e);
    cmp++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic drive(input vec_t t);
    reset = t.rst; imem_req_ready = t.rdy; imem_resp_valid = t.rsp; imem_resp_data = t.rdata;
    redirect_valid = t.redir; redirect_pc = t.rpc; q_full = t.full;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t  tbl[$];
    mreq_t mq[$];
    logic [31:0] pend[$];
    logic [31:0] mpc;
    int epoch, avail, last_due, stall_exp;
    bit prev_redir;
    tbl.push_back(v(1,1,0,0,0,0,0, 0,0,0,0));
    tbl.push_back(v(0,1,0,0,0,0,0, 1,32'h100,0,0));
    tbl.push_back(v(0,1,1,I0,0,0,0, 1,32'h104,1,{32'h100,I0}));
    tbl.push_back(v(0,1,1,I1,0,0,0, 1,32'h108,1,{32'h104,I1}));
    tbl.push_back(v(0,1,1,I2,0,0,0, 1,32'h10C,1,{32'h108,I2}));
    tbl.push_back(v(1,1,0,0,0,0,0, 0,0,0,0));
    tbl.push_back(v(0,1,0,0,0,0,1, 1,32'h100,0,0));
    tbl.push_back(v(0,1,0,0,0,0,1, 1,32'h104,0,0));
    tbl.push_back(v(0,1,1,I0,0,0,1, 0,0,0,0));
    tbl.push_back(v(0,1,1,I1,0,0,1, 0,0,0,0));
    for (int i = 0; i < 6; i++) tbl.push_back(v(0,1,0,0,0,0,1, 0,0,0,0));
    tbl.push_back(v(0,1,0,0,0,0,0, 0,0,1,{32'h100,I0}));
    tbl.push_back(v(0,1,0,0,0,0,0, 1,32'h108,1,{32'h104,I1}));
    tbl.push_back(v(0,1,1,I2,0,0,0, 1,32'h10C,1,{32'h108,I2}));
    tbl.push_back(v(0,1,0,0,0,0,0, 1,32'h110,0,0));
    tbl.push_back(v(0,1,0,0,1,32'h2002,0, 0,0,0,0));
    tbl.push_back(v(0,1,1,X0,0,0,0, 0,0,0,0));
    tbl.push_back(v(0,1,1,X1,0,0,0, 1,32'h2000,0,0));
    tbl.push_back(v(0,1,1,J0,0,0,0, 1,32'h2004,1,{32'h2000,J0}));
    tbl.push_back(v(0,1,1,J1,1,32'hFFFF_FFFF,0, 0,0,0,0));
    tbl.push_back(v(0,1,0,0,0,0,0, 1,32'hFFFF_FFFC,0,0));
    tbl.push_back(v(0,1,1,K0,0,0,0, 1,32'h0,1,{32'hFFFF_FFFC,K0}));
    tbl.push_back(v(0,0,1,K1,0,0,0, 1,32'h4,1,{32'h0,K1}));

    drive(v(1,0,0,0,0,0,0, 0,0,0,0));
    repeat (2) @(posedge clk);
    #1;
    foreach (tbl[i]) begin
      drive(tbl[i]);
      @(negedge clk);
      check($sformatf("row%0d req_valid", i), 64'(imem_req_valid), 64'(tbl[i].erv));
      if (tbl[i].erv) check($sformatf("row%0d req_addr", i), 64'(imem_req_addr), 64'(tbl[i].eaddr));
      check($sformatf("row%0d q_write_en", i), 64'(q_write_en), 64'(tbl[i].ewe));
      if (tbl[i].ewe) check($sformatf("row%0d q_write_data", i), q_write_data, tbl[i].ewd);
      if (i == 1) check("stall_after_reset", 64'(stall_cycles), 64'd0);
      @(posedge clk);
      #1;
    end
`ifdef FETCH_STALL_CNT_EN
    check("stall_table", 64'(stall_cycles), 64'd8);
`else
    check("stall_table", 64'(stall_cycles), 64'd0);
`endif

    drive(v(1,0,0,0,0,0,0, 0,0,0,0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    mpc = 32'h100; epoch = 0; avail = 0; last_due = 0; stall_exp = 0; prev_redir = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit drain, live, exp_rv, exp_we;
      drain           = cyc >= 2800;
      redirect_valid  = !drain && !prev_redir && $urandom_range(0, 15) == 0;
      redirect_pc     = $urandom;
      imem_req_ready  = !drain && $urandom_range(0, 3) != 0;
      q_full          = !drain && $urandom_range(0, 3) == 0;
      imem_resp_valid = mq.size() > 0 && mq[0].due <= cyc;
      imem_resp_data  = imem_resp_valid ? ins(mq[0].a) : $urandom;
      prev_redir      = redirect_valid;
      @(negedge clk);
      live   = imem_resp_valid && mq[0].ep == epoch && !redirect_valid;
      exp_rv = !redirect_valid && (mq.size() + avail) < 2;
      exp_we = !q_full && !redirect_valid && (avail > 0 || live);
      check("rnd req_valid", 64'(imem_req_valid), 64'(exp_rv));
      if (exp_rv && imem_req_valid) check("rnd req_addr", 64'(imem_req_addr), 64'(mpc));
      check("rnd q_write_en", 64'(q_write_en), 64'(exp_we));
      if (exp_we && q_write_en) check("rnd q_write_data", q_write_data, {pend[0], ins(pend[0])});
      check("rnd stall_cycles", 64'(stall_cycles), 64'(stall_exp));
`ifdef FETCH_STALL_CNT_EN
      if (q_full && (avail > 0 || live)) stall_exp++;
`endif
      if (live) avail++;
      if (exp_we) begin
        avail--;
        void'(pend.pop_front());
      end
      if (imem_resp_valid) void'(mq.pop_front());
      if (imem_req_valid && imem_req_ready) begin
        int due;
        due = cyc + int'($urandom_range(1, 3));
        if (due < last_due) due = last_due;
        last_due = due;
        mq.push_back('{a: mpc, due: due, ep: epoch});
        pend.push_back(mpc);
        mpc += 32'd4;
      end
      if (redirect_valid) begin
        epoch++;
        pend.delete();
        avail = 0;
        mpc = {redirect_pc[31:2], 2'b00};
      end
      @(posedge clk);
      #1;
    end
    check("drain_pending_writes", 64'(pend.size()), 64'd0);
    check("drain_memory", 64'(mq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end
endmodule
